// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start/data/stop framing with a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to compile in the parity bit, its check and parity_err.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       baud_pulse,
  output logic       uart_rx_done,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] HalfTick = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
      PARITY_ODD > 1) begin : gen_param_check
    $error("uart_rx_deserializer: OVERSAMPLE must be a power of two in 4..64, PARITY_ODD 0/1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
  logic             sample;

  // Decisions are made on the baud_pulse that lands on the relevant tick.
  assign sample = baud_pulse && (tick_q == LastTick);

`ifdef UART_RX_PARITY_EN
  localparam logic ParityOdd = (PARITY_ODD != 0);

  logic par_mis_q, par_mis_d;
  logic parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_mis_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_mis_q    <= par_mis_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d    = par_mis_q;
    parity_err_d = 1'b0;
`endif

    if (baud_pulse) begin
      tick_d = tick_q + TickW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tick_d    = '0;
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_mis_d = 1'b0;
`endif
        if (!rxs_q) begin
          state_d = StStart;
        end
      end

      // Half a bit in: a line that has gone high again was a glitch.
      StStart: begin
        if (baud_pulse && (tick_q == HalfTick)) begin
          tick_d  = '0;
          state_d = rxs_q ? StIdle : StData;
        end
      end

      StData: begin
        if (sample) begin
          tick_d    = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample) begin
          tick_d    = '0;
          par_mis_d = ((^shift_q) ^ rxs_q) != ParityOdd;
          state_d   = StStop;
        end
      end
`endif

      // Leaving at mid-stop lets a back-to-back start edge be caught.
      StStop: begin
        if (sample) begin
          tick_d = '0;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
`ifdef UART_RX_PARITY_EN
          end else if (par_mis_q) begin
            parity_err_d = 1'b1;
            state_d      = StIdle;
`endif
          end else begin
            done_d    = 1'b1;
            rx_data_d = shift_q;
            state_d   = StIdle;
          end
        end
      end

      StWaitHigh: begin
        tick_d = '0;
        if (rxs_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        tick_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign uart_rx_done = done_q;
  assign rx_data      = rx_data_q;
  assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized bench for uart_rx_deserializer: frames are scored against a per-frame outcome model
// that predicts which pulse appears on which cycle and what rx_data must hold.
module tb_uart_rx_deserializer;

  localparam int unsigned OS     = 16;
  localparam int unsigned PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int NBits   = 11;
  localparam int DoneLat = 171;
`else
  localparam int NBits   = 10;
  localparam int DoneLat = 155;
`endif
  localparam int KNone = 0, KDone = 1, KFerr = 2, KPerr = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       baud;
  logic       done, ferr, perr;
  logic [7:0] rxd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: expected pulse kind/data keyed by the cycle they must be visible.
  int         exp_kind [int];
  logic [7:0] exp_data [int];
  logic [7:0] model_rx = 8'h00;
  int         exp_done_total = 0;

  int         done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, last_done_cyc = -1;
  logic [7:0] got_q[$];

  uart_rx_deserializer #(
    .OVERSAMPLE(OS),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .baud_pulse  (baud),
    .uart_rx_done(done),
    .rx_data     (rxd),
    .frame_err   (ferr),
    .parity_err  (perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    int k;
    if (!rst) begin
      model_rx = 8'h00;
      check("reset_outputs", {21'd0, done, ferr, perr, rxd}, 32'd0);
    end else begin
      k = exp_kind.exists(cyc) ? exp_kind[cyc] : KNone;
      if (k == KDone) model_rx = exp_data[cyc];
      check("cycle_outputs", {21'd0, done, ferr, perr, rxd},
            {21'd0, k == KDone, k == KFerr, k == KPerr, model_rx});
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        got_q.push_back(rxd);
      end
      if (ferr) ferr_cnt++;
      if (perr) perr_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(OS);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the stop bit (plus hold_low).
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                            input bit rel_rst, input int hold_low, output int c0);
    logic [10:0] bits;
    int          kind;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ PAR_ODD[0] ^ par_flip;
    bits[10] = stop_ok;
`else
    bits[9]  = stop_ok;
`endif
    c0 = cyc;
    kind = !stop_ok ? KFerr : (par_flip ? KPerr : KDone);
    // Two synchronizer flops plus the idle-detect register, then half a bit to the start
    // mid-point and one full bit per remaining frame bit to the stop mid-point.
    exp_kind[c0 + 3 + OS / 2 + OS * (NBits - 1)] = kind;
    exp_data[c0 + 3 + OS / 2 + OS * (NBits - 1)] = d;
    if (kind == KDone) exp_done_total++;
    for (int i = 0; i < NBits; i++) begin
      rx = bits[i];
      if (i == 0 && rel_rst) begin
        #3 rst = 1'b1;
        idle(OS);
      end else begin
        idle(OS);
      end
    end
    if (hold_low > 0) idle(hold_low);
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    idle(len);
    rx = 1'b1;
    idle(20);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         c0, base;
    logic [7:0] d;
    bit         ok, pf;
    rst  = 1'b0;
    rx   = 1'b1;
    baud = 1'b1;
    idle(3);
    check("reset_state", {21'd0, done, ferr, perr, rxd}, 32'd0);
    rst = 1'b1;
    idle(5);

    send_frame(8'hA5, 1, 0, 0, 0, c0);
    idle(20);
    check("a5_data", {24'd0, rxd}, 32'hA5);
    check("a5_done_latency", last_done_cyc - c0, DoneLat);
    check("a5_done_count", done_cnt, 1);
    check("a5_no_ferr", ferr_cnt, 0);

    send_frame(8'h3C, 0, 0, 0, 40, c0);
    idle(20);
    check("bad_stop_ferr", ferr_cnt, 1);
    check("bad_stop_no_done", done_cnt, 1);
    check("bad_stop_data_kept", {24'd0, rxd}, 32'hA5);

    send_frame(8'h5A, 1, 0, 0, 0, c0);
    idle(20);
    check("after_ferr_data", {24'd0, rxd}, 32'h5A);

    glitch(4);
    check("glitch_no_done", done_cnt, 2);
    check("glitch_no_ferr", ferr_cnt, 1);
    send_frame(8'h3C, 1, 0, 0, 0, c0);
    idle(20);
    check("after_glitch_data", {24'd0, rxd}, 32'h3C);

    base = done_cnt;
    send_frame(8'h00, 1, 0, 0, 0, c0);
    send_frame(8'hFF, 1, 0, 0, 0, c0);
    send_frame(8'h81, 1, 0, 0, 0, c0);
    idle(20);
    check("b2b_count", done_cnt - base, 3);
    check("b2b_first", {24'd0, got_q[got_q.size() - 3]}, 32'h00);
    check("b2b_second", {24'd0, got_q[got_q.size() - 2]}, 32'hFF);
    check("b2b_third", {24'd0, got_q[got_q.size() - 1]}, 32'h81);

    // Abort 0x77 in the middle of its data bits.
    d = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    #1 rst = 1'b0;
    exp_kind.delete();
    #1 check("rst_async_zero", {21'd0, done, ferr, perr, rxd}, 32'd0);
    rx = 1'b0;
    idle(4);
    base = done_cnt;
    send_frame(8'h12, 1, 0, 1, 0, c0);
    idle(20);
    check("post_reset_data", {24'd0, rxd}, 32'h12);
    check("post_reset_count", done_cnt - base, 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 0, 0, 0, c0);
    idle(20);
    check("par_good_data", {24'd0, rxd}, 32'h07);
    base = perr_cnt;
    send_frame(8'h07, 1, 1, 0, 0, c0);
    idle(20);
    check("par_bad_perr", perr_cnt - base, 1);
    check("par_bad_data_kept", {24'd0, rxd}, 32'h07);
`endif

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch($urandom_range(1, 6));
      end else begin
        d  = 8'($urandom);
        ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
        pf = ($urandom_range(0, 5) == 0);
`else
        pf = 1'b0;
`endif
        send_frame(d, ok, pf, 0, ok ? 0 : int'($urandom_range(0, 40)), c0);
        if (!ok) idle(20);
        else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30));
      end
    end
    idle(300);
    check("all_done_seen", done_cnt, exp_done_total);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter: OVERSAMPLE, 16, baud_pulse ticks per bit; power of two, 4..64.
REQ-002 SHALL have parameter: PARITY_ODD, 0, with parity compiled in: 0 = even parity, 1 = odd parity; ignored otherwise.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port: baud_pulse  input  1  one-clk tick at OVERSAMPLE x bit rate.
REQ-007 SHALL have port: uart_rx_done  output  1  one-clk pulse: valid byte on rx_data, drives RX FIFO push.
REQ-008 SHALL have port: rx_data  output  8  last accepted byte; held until next accepted byte.
REQ-009 SHALL have port: frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 SHALL have port: parity_err  output  1  one-clk pulse: parity mismatch.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (present only with parity compiled in), STOP, WAIT_HIGH.
REQ-013 SHALL keep a log2(OVERSAMPLE)-bit tick counter, advanced only on baud_pulse, cleared on every state entry.
REQ-014 IDLE: rxs==0 in any clk cycle -> START; baud_pulse not required.
REQ-015 START: on the baud_pulse where tick == OVERSAMPLE/2-1, rxs==0 -> DATA; rxs==1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: sample rxs on the baud_pulse where tick == OVERSAMPLE-1; shift LSB-first (shift right, new bit into [7]); after 8th sample -> PARITY (if compiled in) else STOP.
REQ-017 PARITY: sample at tick == OVERSAMPLE-1; record mismatch of XOR(data bits, sample) against PARITY_ODD; -> STOP.
REQ-018 STOP: sample at tick == OVERSAMPLE-1 (mid stop bit); rxs==1 and no parity mismatch -> uart_rx_done=1, rx_data=shift register, -> IDLE.
REQ-019 STOP with rxs==1 and parity mismatch -> parity_err=1, no uart_rx_done, rx_data unchanged, -> IDLE.
REQ-020 STOP with rxs==0 -> frame_err=1 (parity_err suppressed), no uart_rx_done, rx_data unchanged, -> WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until rxs==1 (break/stuck-low line), then -> IDLE; no further flags while waiting.
REQ-022 uart_rx_done, frame_err, parity_err SHALL be registered and asserted in the clk cycle after the deciding baud_pulse, for exactly one cycle; at most one asserts per frame.
REQ-023 Returning to IDLE at mid-stop SHALL allow a back-to-back start bit to be detected with no gap frames.
REQ-024 No backpressure: the consumer (RX FIFO) accepts or drops; the block never stalls.

Reset
REQ-025 rst low SHALL asynchronously force: state=IDLE, tick=0, bit count=0, shift register=0, synchronizer=1, rx_data=8'h00, uart_rx_done=0, frame_err=0, parity_err=0.
REQ-026 Reset mid-frame SHALL discard the partial byte with no pulses; after release, a line held low SHALL be treated as a new start edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state, parity check and parity_err logic present; frame = start + 8 data + parity + stop.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state; frame = start + 8 data + stop; parity_err port present and tied 0.

Verification
REQ-029 Bench: baud_pulse every clk, OVERSAMPLE=16, no parity; send 0xA5 8N1 -> one uart_rx_done pulse, rx_data=0xA5, frame_err=0, done exactly 1 clk after the stop mid-sample tick.
REQ-030 Bench: rx low for 4 ticks then high -> no uart_rx_done, no flags, state returns to IDLE; following 0x3C frame received correctly.
REQ-031 Bench: send 0x3C with stop bit 0, rx held low 40 ticks -> one frame_err pulse, no uart_rx_done, rx_data keeps previous value; next 0x5A frame after rx high received.
REQ-032 Bench: back-to-back 0x00, 0xFF, 0x81 with zero idle -> three done pulses, rx_data 0x00, 0xFF, 0x81 in order.
REQ-033 Bench: rst low mid-DATA of 0x77 -> all outputs 0 immediately; after release, 0x12 frame -> rx_data=0x12.
REQ-034 Bench, UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> uart_rx_done, rx_data=0x07; parity bit 0 -> parity_err pulse, no done.
